// File: rtl/memshare_rqst_profiler.sv
// memShare arrival-request profiler: per-pattern bank occupancy, sequence count and DRC flags,
// queued for the scheduler. Define MEMSHARE_PROFILE_STAT_EN to add saturating DRC counters.
module memshare_rqst_profiler #(
  parameter int unsigned SHARE_GROUP_SIZE     = 5,
  parameter int unsigned RQST_ADDR_BITWIDTH   = 2,
  parameter int unsigned ARR_RQST_TRACK_DEPTH = 4,
  parameter int unsigned MAX_ALLOC_SEQ_NUM    = 2,
  parameter int unsigned SEQ_W                = $clog2(SHARE_GROUP_SIZE + 1),
  parameter int unsigned OCC_W                = $clog2(ARR_RQST_TRACK_DEPTH + 1)
) (
  input  logic                                           sys_clk,
  input  logic                                           rst,
  input  logic                                           flush,
  input  logic                                           rqst_valid,
  output logic                                           rqst_ready,
  input  logic [SHARE_GROUP_SIZE-1:0]                    rqst_flag,
  input  logic [SHARE_GROUP_SIZE*RQST_ADDR_BITWIDTH-1:0] rqst_addr,
  output logic                                           prof_valid,
  input  logic                                           prof_ready,
  output logic [SHARE_GROUP_SIZE-1:0]                    prof_flag,
  output logic [SHARE_GROUP_SIZE*RQST_ADDR_BITWIDTH-1:0] prof_addr,
  output logic [SEQ_W-1:0]                               prof_seq,
  output logic [2:0]                                     prof_drc,
  output logic [OCC_W-1:0]                               occupancy
`ifdef MEMSHARE_PROFILE_STAT_EN
  ,
  input  logic                                           stat_clr,
  output logic [15:0]                                    stat_drc1_cnt,
  output logic [15:0]                                    stat_drc2_cnt,
  output logic [15:0]                                    stat_drc3_cnt
`endif
);

  localparam int unsigned SG     = SHARE_GROUP_SIZE;
  localparam int unsigned AW     = RQST_ADDR_BITWIDTH;
  localparam int unsigned AD_W   = SG * AW;
  localparam int unsigned NB     = 2 ** AW;
  localparam int unsigned DEPTH  = ARR_RQST_TRACK_DEPTH;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned STAT_W = 16;

  logic [SEQ_W-1:0] bank_cnt_c [NB];
  logic [SEQ_W-1:0] seq_c;
  logic [2:0]       drc_c;
  logic             push_c, pop_c;

  logic [SG-1:0]    mem_flag_q [DEPTH], mem_flag_d [DEPTH];
  logic [AD_W-1:0]  mem_addr_q [DEPTH], mem_addr_d [DEPTH];
  logic [SEQ_W-1:0] mem_seq_q  [DEPTH], mem_seq_d  [DEPTH];
  logic [2:0]       mem_drc_q  [DEPTH], mem_drc_d  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [SEQ_W-1:0] last_seq_q, last_seq_d;
  logic             rqst_ready_q, rqst_ready_d, prof_valid_q, prof_valid_d;
  logic [SG-1:0]    prof_flag_q, prof_flag_d;
  logic [AD_W-1:0]  prof_addr_q, prof_addr_d;
  logic [SEQ_W-1:0] prof_seq_q, prof_seq_d;
  logic [2:0]       prof_drc_q, prof_drc_d;

  // Profile of the incoming pattern: per-bank count of active requestors, max, DRC flags
  always_comb begin
    for (int unsigned b = 0; b < NB; b++) begin
      bank_cnt_c[b] = '0;
      for (int unsigned i = 0; i < SG; i++) begin
        if (rqst_flag[i] && (rqst_addr[i*AW +: AW] == AW'(b))) begin
          bank_cnt_c[b] = bank_cnt_c[b] + SEQ_W'(1);
        end
      end
    end
    seq_c = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      if (bank_cnt_c[b] > seq_c) seq_c = bank_cnt_c[b];
    end
    drc_c[0] = (seq_c > SEQ_W'(1));
    drc_c[1] = (seq_c > SEQ_W'(MAX_ALLOC_SEQ_NUM));
    drc_c[2] = (seq_c > SEQ_W'(1)) && (last_seq_q > SEQ_W'(1));
  end

  // A flush cycle neither pushes nor pops; the pattern presented with it is dropped
  assign push_c = rqst_valid && rqst_ready_q && !flush;
  assign pop_c  = prof_valid_q && prof_ready && !flush;

  always_comb begin
    mem_flag_d = mem_flag_q;
    mem_addr_d = mem_addr_q;
    mem_seq_d  = mem_seq_q;
    mem_drc_d  = mem_drc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    last_seq_d = last_seq_q;

    if (push_c) begin
      mem_flag_d[wr_ptr_q] = rqst_flag;
      mem_addr_d[wr_ptr_q] = rqst_addr;
      mem_seq_d[wr_ptr_q]  = seq_c;
      mem_drc_d[wr_ptr_q]  = drc_c;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      last_seq_d           = seq_c;
    end
    if (pop_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    if (push_c && !pop_c)      occ_d = occ_q + OCC_W'(1);
    else if (pop_c && !push_c) occ_d = occ_q - OCC_W'(1);

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      occ_d      = '0;
      last_seq_d = '0;
    end

    // Handshake and head outputs are registered from the next-state view of the FIFO
    rqst_ready_d = (occ_d != OCC_W'(DEPTH));
    prof_valid_d = (occ_d != '0);
    prof_flag_d  = prof_valid_d ? mem_flag_d[rd_ptr_d] : '0;
    prof_addr_d  = prof_valid_d ? mem_addr_d[rd_ptr_d] : '0;
    prof_seq_d   = prof_valid_d ? mem_seq_d[rd_ptr_d]  : '0;
    prof_drc_d   = prof_valid_d ? mem_drc_d[rd_ptr_d]  : '0;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      mem_flag_q   <= '{default: '0};
      mem_addr_q   <= '{default: '0};
      mem_seq_q    <= '{default: '0};
      mem_drc_q    <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      last_seq_q   <= '0;
      rqst_ready_q <= 1'b1;
      prof_valid_q <= 1'b0;
      prof_flag_q  <= '0;
      prof_addr_q  <= '0;
      prof_seq_q   <= '0;
      prof_drc_q   <= '0;
    end else begin
      mem_flag_q   <= mem_flag_d;
      mem_addr_q   <= mem_addr_d;
      mem_seq_q    <= mem_seq_d;
      mem_drc_q    <= mem_drc_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      last_seq_q   <= last_seq_d;
      rqst_ready_q <= rqst_ready_d;
      prof_valid_q <= prof_valid_d;
      prof_flag_q  <= prof_flag_d;
      prof_addr_q  <= prof_addr_d;
      prof_seq_q   <= prof_seq_d;
      prof_drc_q   <= prof_drc_d;
    end
  end

  assign rqst_ready = rqst_ready_q;
  assign prof_valid = prof_valid_q;
  assign prof_flag  = prof_flag_q;
  assign prof_addr  = prof_addr_q;
  assign prof_seq   = prof_seq_q;
  assign prof_drc   = prof_drc_q;
  assign occupancy  = occ_q;

`ifdef MEMSHARE_PROFILE_STAT_EN
  logic [STAT_W-1:0] stat_drc1_cnt_q, stat_drc1_cnt_d;
  logic [STAT_W-1:0] stat_drc2_cnt_q, stat_drc2_cnt_d;
  logic [STAT_W-1:0] stat_drc3_cnt_q, stat_drc3_cnt_d;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] cnt, input logic en);
    return (en && (cnt != '1)) ? cnt + STAT_W'(1) : cnt;
  endfunction

  // Counters survive flush; stat_clr overrides a same-cycle increment
  always_comb begin
    stat_drc1_cnt_d = sat_inc(stat_drc1_cnt_q, push_c && drc_c[0]);
    stat_drc2_cnt_d = sat_inc(stat_drc2_cnt_q, push_c && drc_c[1]);
    stat_drc3_cnt_d = sat_inc(stat_drc3_cnt_q, push_c && drc_c[2]);
    if (stat_clr) begin
      stat_drc1_cnt_d = '0;
      stat_drc2_cnt_d = '0;
      stat_drc3_cnt_d = '0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      stat_drc1_cnt_q <= '0;
      stat_drc2_cnt_q <= '0;
      stat_drc3_cnt_q <= '0;
    end else begin
      stat_drc1_cnt_q <= stat_drc1_cnt_d;
      stat_drc2_cnt_q <= stat_drc2_cnt_d;
      stat_drc3_cnt_q <= stat_drc3_cnt_d;
    end
  end

  assign stat_drc1_cnt = stat_drc1_cnt_q;
  assign stat_drc2_cnt = stat_drc2_cnt_q;
  assign stat_drc3_cnt = stat_drc3_cnt_q;
`endif

endmodule

// File: tb/tb_memshare_rqst_profiler.sv
// Directed bench for memshare_rqst_profiler (W=2, group of 5, depth 4).
module tb_memshare_rqst_profiler;

  logic       sys_clk = 1'b0;
  logic       rst, flush, rqst_valid, rqst_ready, prof_valid, prof_ready;
  logic [4:0] rqst_flag, prof_flag;
  logic [9:0] rqst_addr, prof_addr;
  logic [2:0] prof_seq, prof_drc, occupancy;
`ifdef MEMSHARE_PROFILE_STAT_EN
  logic        stat_clr;
  logic [15:0] stat_drc1_cnt, stat_drc2_cnt, stat_drc3_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  memshare_rqst_profiler dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .flush      (flush),
    .rqst_valid (rqst_valid),
    .rqst_ready (rqst_ready),
    .rqst_flag  (rqst_flag),
    .rqst_addr  (rqst_addr),
    .prof_valid (prof_valid),
    .prof_ready (prof_ready),
    .prof_flag  (prof_flag),
    .prof_addr  (prof_addr),
    .prof_seq   (prof_seq),
    .prof_drc   (prof_drc),
    .occupancy  (occupancy)
`ifdef MEMSHARE_PROFILE_STAT_EN
    ,
    .stat_clr      (stat_clr),
    .stat_drc1_cnt (stat_drc1_cnt),
    .stat_drc2_cnt (stat_drc2_cnt),
    .stat_drc3_cnt (stat_drc3_cnt)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] f, input logic [9:0] a);
    rqst_valid = v;
    rqst_flag  = f;
    rqst_addr  = a;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; prof_ready = 1'b0;
    drive(1'b0, 5'b0, 10'h0);
`ifdef MEMSHARE_PROFILE_STAT_EN
    stat_clr = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_valid", 32'(prof_valid), 32'd0);
    chk("rst_ready", 32'(rqst_ready), 32'd1);
    chk("rst_seq", 32'(prof_seq), 32'd0);
    chk("rst_drc", 32'(prof_drc), 32'd0);
    chk("rst_flag", 32'(prof_flag), 32'd0);

    // Two requestors on bank 0
    drive(1'b1, 5'b00101, 10'h000);
    tick();
    drive(1'b0, 5'b0, 10'h0);
    chk("t1_valid", 32'(prof_valid), 32'd1);
    chk("t1_seq", 32'(prof_seq), 32'd2);
    chk("t1_drc", 32'(prof_drc), 32'b001);
    chk("t1_flag", 32'(prof_flag), 32'b00101);
    chk("t1_occ", 32'(occupancy), 32'd1);
    prof_ready = 1'b1;
    tick();
    prof_ready = 1'b0;
    chk("t1_pop_occ", 32'(occupancy), 32'd0);
    chk("t1_pop_valid", 32'(prof_valid), 32'd0);

    // Fresh history, then three-way conflict followed by a two-way conflict
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b1, 5'b10101, 10'h000);
    tick();
    chk("t2a_seq", 32'(prof_seq), 32'd3);
    chk("t2a_drc", 32'(prof_drc), 32'b011);
    drive(1'b1, 5'b00101, 10'h000);
    tick();
    drive(1'b0, 5'b0, 10'h0);
    chk("t2_occ", 32'(occupancy), 32'd2);
    chk("t2_head_hold", 32'(prof_flag), 32'b10101);
    prof_ready = 1'b1;
    tick();
    chk("t2b_seq", 32'(prof_seq), 32'd2);
    chk("t2b_drc", 32'(prof_drc), 32'b101);
    tick();
    prof_ready = 1'b0;
    chk("t2_empty", 32'(prof_valid), 32'd0);

    // All-zero flag, inactive requestors ignored, distinct banks
    drive(1'b1, 5'b00000, 10'h3FF);
    tick();
    chk("zero_seq", 32'(prof_seq), 32'd0);
    chk("zero_drc", 32'(prof_drc), 32'd0);
    chk("zero_valid", 32'(prof_valid), 32'd1);
    drive(1'b1, 5'b00011, 10'h159);
    prof_ready = 1'b1;
    tick();
    chk("inact_seq", 32'(prof_seq), 32'd1);
    chk("inact_drc", 32'(prof_drc), 32'd0);
    chk("inact_addr", 32'(prof_addr), 32'h159);
    drive(1'b1, 5'b11111, 10'h0E4);
    tick();
    drive(1'b0, 5'b0, 10'h0);
    chk("banks_seq", 32'(prof_seq), 32'd2);
    chk("banks_drc", 32'(prof_drc), 32'b001);
    tick();
    prof_ready = 1'b0;
    chk("banks_empty", 32'(occupancy), 32'd0);

    // Fill to full with scheduler stalled; fifth push must be refused
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 5'(k + 1), 10'h000);
      tick();
      chk("fill_occ", 32'(occupancy), (k < 4) ? 32'(k + 1) : 32'd4);
      chk("fill_ready", 32'(rqst_ready), (k < 3) ? 32'd1 : 32'd0);
      chk("fill_head", 32'(prof_flag), 32'd1);
    end
    drive(1'b1, 5'b11111, 10'h000);
    prof_ready = 1'b1;
    tick();
    drive(1'b0, 5'b0, 10'h0);
    chk("full_pp_occ", 32'(occupancy), 32'd3);
    chk("full_pp_head", 32'(prof_flag), 32'd2);
    chk("full_pp_ready", 32'(rqst_ready), 32'd1);
    tick();
    chk("drain_h3", 32'(prof_flag), 32'd3);
    tick();
    chk("drain_h4", 32'(prof_flag), 32'd4);
    tick();
    chk("drain_occ", 32'(occupancy), 32'd0);
    chk("drain_valid", 32'(prof_valid), 32'd0);

    // Steady push+pop at occupancy 2 across several pointer wraps
    prof_ready = 1'b0;
    drive(1'b1, 5'd1, 10'h000);
    tick();
    drive(1'b1, 5'd2, 10'h000);
    tick();
    chk("pp_pre_occ", 32'(occupancy), 32'd2);
    prof_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 5'(k + 3), 10'h000);
      tick();
      chk("pp_occ", 32'(occupancy), 32'd2);
      chk("pp_head", 32'(prof_flag), 32'(k + 2));
    end

    // Flush with three entries and a pattern presented: all dropped, history cleared
    prof_ready = 1'b0;
    drive(1'b1, 5'b00101, 10'h000);
    tick();
    chk("pre_flush_occ", 32'(occupancy), 32'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 5'b0, 10'h0);
    chk("flush_occ", 32'(occupancy), 32'd0);
    chk("flush_valid", 32'(prof_valid), 32'd0);
    chk("flush_ready", 32'(rqst_ready), 32'd1);
    chk("flush_flag", 32'(prof_flag), 32'd0);
    drive(1'b1, 5'b00101, 10'h000);
    tick();
    drive(1'b0, 5'b0, 10'h0);
    chk("post_flush_occ", 32'(occupancy), 32'd1);
    chk("post_flush_drc", 32'(prof_drc), 32'b001);
    prof_ready = 1'b1;
    tick();
    chk("post_flush_empty", 32'(occupancy), 32'd0);

`ifdef MEMSHARE_PROFILE_STAT_EN
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("stat_clr1", 32'(stat_drc1_cnt), 32'd0);
    chk("stat_clr3", 32'(stat_drc3_cnt), 32'd0);
    drive(1'b1, 5'b00101, 10'h000);
    tick(); tick(); tick();
    chk("stat_d1_3", 32'(stat_drc1_cnt), 32'd3);
    chk("stat_d2_0", 32'(stat_drc2_cnt), 32'd0);
    chk("stat_d3_3", 32'(stat_drc3_cnt), 32'd3);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    drive(1'b0, 5'b0, 10'h0);
    chk("stat_clr_wins", 32'(stat_drc1_cnt), 32'd0);
    force dut.stat_drc1_cnt_q = 16'hFFFF;
    #1;
    release dut.stat_drc1_cnt_q;
    drive(1'b1, 5'b00101, 10'h000);
    tick();
    chk("stat_sat1", 32'(stat_drc1_cnt), 32'hFFFF);
    tick();
    drive(1'b0, 5'b0, 10'h0);
    chk("stat_sat2", 32'(stat_drc1_cnt), 32'hFFFF);
    chk("stat_d3_2", 32'(stat_drc3_cnt), 32'd2);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
